fetch_cycle: RTL
================

FETCH_CYCLE -- requirements
Module: fetch_cycle

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC fetched first after reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble instruction (ADDI x0,x0,0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 StallF  input  1  hold IF/ID register; no PC advance into decode.
REQ-006 FlushD  input  1  replace IF/ID contents with bubble.
REQ-007 PCSelectE  input  1  redirect request from execute (branch/jump taken).
REQ-008 PCTargetE  input  32  redirect target address.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  request address, equals fetch PC.
REQ-011 imem_ready  input  1  transaction completes in a cycle with imem_req && imem_ready.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_ready.
REQ-013 instructionF  output  32  IF/ID instruction to decode.
REQ-014 PCF  output  32  IF/ID PC of instructionF.
REQ-015 PCPlus4F  output  32  PCF + 4, combinational.
REQ-016 ValidF  output  1  instructionF is a real fetched instruction.

Function
REQ-017 The block SHALL hold fetch PC pc_q (imem_addr = pc_q) and a state machine with states FETCH, DISCARD, HOLD.
REQ-018 The block SHALL drive imem_req = 1 in FETCH and DISCARD, 0 in HOLD and while reset is asserted.
REQ-019 imem_addr SHALL stay constant while imem_req is high and imem_ready low; an issued request is never withdrawn.
REQ-020 Completion in FETCH with StallF=0, no redirect, no FlushD SHALL load instructionF<=imem_rdata, PCF<=pc_q, ValidF<=1, pc_q<=pc_q+4 (mod 2^32), stay FETCH.
REQ-021 Completion in FETCH with StallF=1 SHALL store {imem_rdata, pc_q} in a one-entry hold buffer, advance pc_q by 4, go HOLD; IF/ID unchanged.
REQ-022 In HOLD with StallF=0 the buffer SHALL load into IF/ID with ValidF=1 and state SHALL return to FETCH, next fetch issued the following cycle.
REQ-023 In FETCH with no completion and StallF=0, IF/ID SHALL load NOP_INSTR, PCF unchanged, ValidF=0 (bubble).
REQ-024 PCSelectE=1 SHALL set pc_q<=PCTargetE with bits[1:0] forced to 0, IF/ID<=NOP_INSTR/ValidF=0, and discard the hold buffer.
REQ-025 Redirect in FETCH with no completion that cycle SHALL go DISCARD: request kept at old address until imem_ready, data dropped, then FETCH at the new pc_q.
REQ-026 Redirect in FETCH coinciding with completion, or in HOLD, SHALL drop that data and go FETCH at target next cycle.
REQ-027 Redirect in DISCARD SHALL overwrite the pending target and remain in DISCARD.
REQ-028 FlushD=1 SHALL load NOP_INSTR into IF/ID with ValidF=0 without changing pc_q or state; a completion that cycle is kept (in buffer if StallF=1, else consumed with pc_q advance but not presented).
REQ-029 IF/ID update priority SHALL be reset > PCSelectE > FlushD > StallF > normal.
REQ-030 Fetch latency SHALL be one cycle from completion to instructionF/PCF visible at decode when unstalled.

Reset
REQ-031 On reset low, asynchronously: pc_q=RESET_PC, state=FETCH, instructionF=NOP_INSTR, PCF=0, ValidF=0, hold buffer empty, imem_req=0.
REQ-032 Reset asserted mid-transaction SHALL abandon it; first request after release SHALL be at RESET_PC.
REQ-033 First imem_req SHALL assert in the first cycle after reset deasserts.

Verification
REQ-034 Zero-wait memory, no stalls, words 0x00500093,0x00100113 at 0x0,0x4 -> instructionF/PCF = 0x00500093/0x0 then 0x00100113/0x4, ValidF=1, PCPlus4F=0x4 then 0x8.
REQ-035 Memory 2-cycle latency -> imem_addr held at 0x0 for 3 cycles, one bubble pair (NOP_INSTR, ValidF=0) before each instruction.
REQ-036 StallF=1 for 3 cycles during completion at 0x8 -> IF/ID frozen, imem_req low in HOLD, buffered word appears with PCF=0x8 one cycle after StallF drops, no duplicate or lost fetch.
REQ-037 PCSelectE=1, PCTargetE=0x103 while request to 0xC outstanding -> DISCARD, 0xC data dropped, next request at 0x100, IF/ID shows NOP_INSTR/ValidF=0 until 0x100 word arrives.
REQ-038 FlushD=1 with StallF=1 -> instructionF=NOP_INSTR, ValidF=0, pc_q unchanged.
REQ-039 reset low mid-wait at 0x20 -> outputs at reset values immediately; after release, imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: fetch PC, imem request handshake and IF/ID register.
// Handles decode stalls via a one-entry hold buffer and redirects via a discard state.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSelectE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instructionF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] DISCARD = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        buf_vld_q, buf_vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic        valid_q, valid_d;

  logic        done;
  logic        load_fetch;
  logic        load_buf;
  logic [31:0] tgt_in;
  logic [31:0] pc_inc;

  assign imem_req     = reset & (state_q != HOLD);
  assign imem_addr    = pc_q;
  assign instructionF = instr_q;
  assign PCF          = pcf_q;
  assign ValidF       = valid_q;
  assign PCPlus4F     = pcf_q + 32'd4;

  assign done   = imem_req & imem_ready;
  assign tgt_in = {PCTargetE[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  // Fetch PC, pending redirect target and hold buffer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_vld_d   = buf_vld_q;
    unique case (state_q)
      FETCH: begin
        if (PCSelectE) begin
          if (done) begin
            pc_d = tgt_in;
          end else begin
            tgt_d   = tgt_in;
            state_d = DISCARD;
          end
        end else if (done) begin
          pc_d = pc_inc;
          if (StallF) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            buf_vld_d   = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      DISCARD: begin
        // The old request must finish before the new PC can be issued.
        if (done) begin
          pc_d    = PCSelectE ? tgt_in : tgt_q;
          state_d = FETCH;
        end else if (PCSelectE) begin
          tgt_d = tgt_in;
        end
      end
      HOLD: begin
        if (PCSelectE) begin
          pc_d      = tgt_in;
          buf_vld_d = 1'b0;
          state_d   = FETCH;
        end else if (!FlushD && !StallF) begin
          buf_vld_d = 1'b0;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign load_fetch = (state_q == FETCH) & done & ~StallF;
  assign load_buf   = (state_q == HOLD) & buf_vld_q & ~StallF;

  // IF/ID register: redirect > flush > stall > new word > bubble.
  always_comb begin
    instr_d = instr_q;
    pcf_d   = pcf_q;
    valid_d = valid_q;
    if (PCSelectE || FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (StallF) begin
      instr_d = instr_q;
    end else if (load_fetch) begin
      instr_d = imem_rdata;
      pcf_d   = pc_q;
      valid_d = 1'b1;
    end else if (load_buf) begin
      instr_d = buf_instr_q;
      pcf_d   = buf_pc_q;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      tgt_q       <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      buf_vld_q   <= 1'b0;
      instr_q     <= NOP_INSTR;
      pcf_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_vld_q   <= buf_vld_d;
      instr_q     <= instr_d;
      pcf_q       <= pcf_d;
      valid_q     <= valid_d;
    end
  end

endmodule
